pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter STALL_CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002 Parameter FLUSH_CNT_W, default 8, width of the saturating flush-event counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 i_idex_memRead input 1: ID/EX stage holds a load.
REQ-005 i_idex_rt input 5: ID/EX load destination register.
REQ-006 i_ifid_rs, i_ifid_rt input 5 each: IF/ID source registers.
REQ-007 i_ex_jump input 1: jump resolved in EX.
REQ-008 i_mem_branch_taken input 1: branch resolved taken in MEM.
REQ-009 i_mem_busy input 1: data memory not ready; whole pipeline must freeze.
REQ-010 o_pc_write output 1: PC update enable.
REQ-011 o_ifid_write output 1: IF/ID buffer load enable.
REQ-012 o_idex_bubble output 1: zero all ID/EX control fields (branch, memRead, memWrite, regWrite, jump, aluOp) on next edge.
REQ-013 o_pipe_hold output 1: ID/EX, EX/MEM, MEM/WB buffers retain contents.
REQ-014 o_ifid_flush, o_idex_flush, o_exmem_flush output 1 each: clear that buffer's control fields.
REQ-015 o_state output 2: registered last-cycle action: 00 RUN, 01 LOAD_STALL, 10 MEM_WAIT, 11 FLUSH.
REQ-016 o_stall_cycles output STALL_CNT_W; o_flush_count output FLUSH_CNT_W.

Function
REQ-017 Control outputs SHALL be combinational from inputs, state and pending flag (zero-latency); o_state, pending flag and counters SHALL be registered.
REQ-018 Load-use hazard SHALL be i_idex_memRead=1 and i_idex_rt!=0 and (i_idex_rt==i_ifid_rs or i_idex_rt==i_ifid_rt).
REQ-019 Per-cycle priority SHALL be: mem_busy > branch_taken-or-pending > ex_jump > load-use > normal.
REQ-020 mem_busy: pc_write=0, ifid_write=0, pipe_hold=1, bubble=0, all flushes=0; next state MEM_WAIT.
REQ-021 branch_taken=1 while mem_busy=1 SHALL set the pending flag; pending SHALL clear on the first non-busy cycle, when the flush is applied.
REQ-022 Branch (or pending): pc_write=1, ifid_write=1, all three flushes=1; next state FLUSH; flush_count += 1.
REQ-023 Jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=0; next state FLUSH; flush_count += 1.
REQ-024 Load-use: pc_write=0, ifid_write=0, bubble=1, pipe_hold=0; next state LOAD_STALL.
REQ-025 Normal: pc_write=1, ifid_write=1, all other controls 0; next state RUN.
REQ-026 Stall counter SHALL increment once per LOAD_STALL or MEM_WAIT cycle; both counters SHALL saturate at all-ones, never wrap.
REQ-027 A load-use hazard coincident with a branch or jump SHALL NOT stall; the flush wins.
REQ-028 Back-to-back hazards SHALL each be handled independently; no cycle-count limit.

Reset
REQ-029 While rst=1: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_pipe_hold=0, all flushes=0.
REQ-030 rst SHALL asynchronously force o_state=RUN, pending=0, both counters=0, including mid-stall and mid-MEM_WAIT.
REQ-031 First edge after rst release SHALL evaluate inputs normally.

Verification
REQ-032 memRead=1, idex_rt=8, ifid_rs=8 -> pc_write=0, ifid_write=0, bubble=1; next o_state=01; stall_cycles=1.
REQ-033 memRead=1, idex_rt=0, ifid_rs=0 -> no stall; pc_write=1, o_state=00.
REQ-034 mem_busy=1 for 3 cycles with branch_taken pulsed in cycle 2 -> pipe_hold=1 three cycles; cycle 4 all flushes=1; flush_count=1; stall_cycles=3.
REQ-035 ex_jump=1 and load-use same cycle -> ifid/idex_flush=1, exmem_flush=0, bubble=0, pc_write=1; o_state=11.
REQ-036 Preload stall counter near max, hold mem_busy -> o_stall_cycles sticks at 0xFFFF.
REQ-037 Assert rst during MEM_WAIT with pending set -> o_state=00, counters 0; after release with no inputs, no flush occurs.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, memory-wait freeze,
// branch/jump flushes, with saturating stall and flush statistics.
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int FLUSH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_idex_memRead,
  input  logic [4:0]             i_idex_rt,
  input  logic [4:0]             i_ifid_rs,
  input  logic [4:0]             i_ifid_rt,
  input  logic                   i_ex_jump,
  input  logic                   i_mem_branch_taken,
  input  logic                   i_mem_busy,
  output logic                   o_pc_write,
  output logic                   o_ifid_write,
  output logic                   o_idex_bubble,
  output logic                   o_pipe_hold,
  output logic                   o_ifid_flush,
  output logic                   o_idex_flush,
  output logic                   o_exmem_flush,
  output logic [1:0]             o_state,
  output logic [STALL_CNT_W-1:0] o_stall_cycles,
  output logic [FLUSH_CNT_W-1:0] o_flush_count
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_MEM_WAIT   = 2'b10,
    ST_FLUSH      = 2'b11
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic pipe_hold;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  state_e                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [FLUSH_CNT_W-1:0] flush_q;
  ctrl_t                  ctrl;
  logic                   load_use;

  assign load_use = i_idex_memRead && (i_idex_rt != 5'd0) &&
                    ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

  // A taken branch seen during a memory freeze is remembered and flushed on
  // the first cycle the memory is ready again.
  assign pending_d = i_mem_busy ? (pending_q | i_mem_branch_taken) : 1'b0;

  always_comb begin
    ctrl    = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
    state_d = ST_RUN;
    if (i_mem_busy) begin
      ctrl    = '{pipe_hold: 1'b1, default: 1'b0};
      state_d = ST_MEM_WAIT;
    end else if (i_mem_branch_taken || pending_q) begin
      ctrl    = '{idex_bubble: 1'b0, pipe_hold: 1'b0, default: 1'b1};
      state_d = ST_FLUSH;
    end else if (i_ex_jump) begin
      ctrl    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                  idex_flush: 1'b1, default: 1'b0};
      state_d = ST_FLUSH;
    end else if (load_use) begin
      ctrl    = '{idex_bubble: 1'b1, default: 1'b0};
      state_d = ST_LOAD_STALL;
    end
    if (rst) ctrl = '{idex_bubble: 1'b1, default: 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pending_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if ((state_d == ST_LOAD_STALL || state_d == ST_MEM_WAIT) && stall_q != '1)
        stall_q <= stall_q + STALL_CNT_W'(1);
      if (state_d == ST_FLUSH && flush_q != '1)
        flush_q <= flush_q + FLUSH_CNT_W'(1);
    end
  end

  assign o_pc_write     = ctrl.pc_write;
  assign o_ifid_write   = ctrl.ifid_write;
  assign o_idex_bubble  = ctrl.idex_bubble;
  assign o_pipe_hold    = ctrl.pipe_hold;
  assign o_ifid_flush   = ctrl.ifid_flush;
  assign o_idex_flush   = ctrl.idex_flush;
  assign o_exmem_flush  = ctrl.exmem_flush;
  assign o_state        = state_q;
  assign o_stall_cycles = stall_q;
  assign o_flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: control outputs checked mid-cycle,
// registered state/counters checked after each edge.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic memrd = 1'b0, jmp = 1'b0, br = 1'b0, busy = 1'b0;
  logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic pc_w, ifid_w, bub, hold, f_ifid, f_idex, f_exmem;
  logic [1:0] st;
  logic [15:0] stall_cnt;
  logic [7:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [1:0] st; logic [15:0] stall; logic [7:0] flush; } regs_t;
  logic [6:0] ctrl_q[$];
  regs_t      regs_q[$];

  int m_state, m_pend, m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .i_idex_memRead(memrd), .i_idex_rt(idex_rt), .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
    .i_ex_jump(jmp), .i_mem_branch_taken(br), .i_mem_busy(busy),
    .o_pc_write(pc_w), .o_ifid_write(ifid_w), .o_idex_bubble(bub), .o_pipe_hold(hold),
    .o_ifid_flush(f_ifid), .o_idex_flush(f_idex), .o_exmem_flush(f_exmem),
    .o_state(st), .o_stall_cycles(stall_cnt), .o_flush_count(flush_cnt)
  );

  wire [6:0] ctrl_obs = {pc_w, ifid_w, bub, hold, f_ifid, f_idex, f_exmem};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves at the following posedge+1.
  task automatic cycle(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                       input logic [4:0] rt_id, input logic j, input logic b, input logic bz);
    logic [6:0] exp_ctrl;
    int ns, np;
    logic ld;
    memrd = mr; idex_rt = rt_ex; ifid_rs = rs_id; ifid_rt = rt_id;
    jmp = j; br = b; busy = bz;
    ld = mr && rt_ex != 0 && (rt_ex == rs_id || rt_ex == rt_id);
    //            pc ifw bub hold fif fid fex
    if (bz)                  begin exp_ctrl = 7'b0001000; ns = 2; np = (m_pend != 0 || b) ? 1 : 0; end
    else if (b || m_pend != 0) begin exp_ctrl = 7'b1100111; ns = 3; np = 0; end
    else if (j)              begin exp_ctrl = 7'b1100110; ns = 3; np = 0; end
    else if (ld)             begin exp_ctrl = 7'b0010000; ns = 1; np = 0; end
    else                     begin exp_ctrl = 7'b1100000; ns = 0; np = 0; end
    ctrl_q.push_back(exp_ctrl);
    m_state = ns; m_pend = np;
    if (ns == 1 || ns == 2) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
    if (ns == 3)            m_flush = (m_flush >= 255) ? 255 : m_flush + 1;
    regs_q.push_back('{st: 2'(m_state), stall: 16'(m_stall), flush: 8'(m_flush)});
    @(negedge clk);
    chk("ctrl", {25'd0, ctrl_obs}, {25'd0, ctrl_q.pop_front()});
    @(posedge clk);
    #1;
    begin
      regs_t r;
      r = regs_q.pop_front();
      chk("state", {30'd0, st}, {30'd0, r.st});
      chk("stall_cycles", {16'd0, stall_cnt}, {16'd0, r.stall});
      chk("flush_count", {24'd0, flush_cnt}, {24'd0, r.flush});
    end
  endtask

  task automatic idle(); cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); endtask

  // Called at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic do_reset();
    memrd = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; jmp = 0; br = 0; busy = 0;
    rst = 1'b1;
    #1;
    chk("rst_ctrl", {25'd0, ctrl_obs}, 32'b0010000);
    chk("rst_state", {30'd0, st}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush", {24'd0, flush_cnt}, 32'd0);
    m_state = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1;
    chk("rst_hold_state", {30'd0, st}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    m_state = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    do_reset();

    // load-use on rs
    cycle(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
    chk("lu_state", {30'd0, st}, 32'd1);
    chk("lu_stall", {16'd0, stall_cnt}, 32'd1);
    // load-use on rt, then r0 destination never stalls
    cycle(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("r0_state", {30'd0, st}, 32'd0);
    cycle(1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0);

    // memory wait with branch arriving mid-freeze
    do_reset();
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_state", {30'd0, st}, 32'd3);
    chk("bp_flush", {24'd0, flush_cnt}, 32'd1);
    chk("bp_stall", {16'd0, stall_cnt}, 32'd3);
    idle();

    // jump coincident with load-use: flush wins
    cycle(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("jmp_state", {30'd0, st}, 32'd3);
    // branch coincident with jump and load-use
    cycle(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    // back-to-back load-use stalls
    repeat (4) cycle(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);

    // reset during MEM_WAIT with pending branch; no flush afterwards
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    do_reset();
    idle();
    chk("post_rst_state", {30'd0, st}, 32'd0);
    chk("post_rst_flush", {24'd0, flush_cnt}, 32'd0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 4) == 0));
    end

    // flush counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_sat", {24'd0, flush_cnt}, 32'hFF);

    // stall counter saturation
    do_reset();
    for (int i = 0; i < 65540; i++) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    idle();
    chk("stall_sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
